pic24_icsp_six_sender: RTL and testbench

Downstream consumer of the PIC24 program memory. On `start`, it reads `count` instruction words from address 0 upward and serialises each as an ICSP SIX packet onto PGC/PGD toward the target device. Each packet is a 4-bit SIX command (0000) followed by a 24-bit operand, LSB first. It owns the memory read port (addr/ce/we) while busy.

---
 rtl/pic24_icsp_pkg.sv | 21 ++
 rtl/pic24_icsp_six_sender_bitclk.sv | 46 ++++
 rtl/pic24_icsp_six_sender.sv | 221 ++++++++++++++++++++++
 tb/tb_pic24_icsp_six_sender.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic24_icsp_pkg.sv
// Shared types and constants for the PIC24 ICSP SIX packet sender.
// S_NOP exists only when PIC24_ICSP_NOPPAD_EN is defined.
package pic24_icsp_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
`ifdef PIC24_ICSP_NOPPAD_EN
        S_NOP   = 3'd5,
`endif
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0]  SIX_CMD      = 4'b0000;
    localparam int          PKT_BITS     = 28;
    localparam int          OPERAND_BITS = 24;
    localparam logic [23:0] NOP_OPERAND  = 24'h000000;

endpackage

// File: rtl/pic24_icsp_six_sender_bitclk.sv
// PGC half-period timer: tick_o on the last clock of each half, phase_hi_o marks the high half.
// Disabled (en_i=0) it parks at count 0 in the high phase so the next bit starts cleanly.
module pic24_icsp_bitclk #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    output logic tick_o,
    output logic phase_hi_o
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign tick_o     = en_i && (cnt_q == LAST);
    assign phase_hi_o = phase_q;

endmodule

// File: rtl/pic24_icsp_six_sender.sv
// Reads count words from memory address 0 up and sends each as an ICSP SIX packet (4-bit cmd + 24-bit operand, LSB first).
// PIC24_ICSP_NOPPAD_EN appends a zero-operand SIX packet after every word.
module pic24_icsp_six_sender
    import pic24_icsp_pkg::*;
#(
    parameter int DATAWIDTH   = 32,
    parameter int MEMSIZElog2 = 7,
    parameter int CLKDIV      = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [MEMSIZElog2:0]   count,
    output logic                   busy,
    output logic                   done,
    output logic [MEMSIZElog2-1:0] mem_addr,
    output logic                   mem_ce,
    output logic                   mem_we,
    input  logic [DATAWIDTH-1:0]   mem_dout,
    output logic                   pgc,
    output logic                   pgd,
    output logic                   pgd_oe
);

    localparam logic [4:0] LAST_BIT = 5'(PKT_BITS - 1);

    state_t                 state_q, state_d;
    logic [MEMSIZElog2:0]   rem_q, rem_d;
    logic [MEMSIZElog2-1:0] addr_q, addr_d;
    logic                   ce_q, ce_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pgc_q, pgc_d;
    logic                   pgd_q, pgd_d;
    logic                   oe_q, oe_d;
    logic [PKT_BITS-1:0]    shift_q, shift_d;
    logic [4:0]             bit_q, bit_d;
    logic                   shifting, tick, phase_hi, advance;
`ifdef PIC24_ICSP_NOPPAD_EN
    logic                   nop_run_q, nop_run_d;
    logic                   gap_q, gap_d;
`endif

`ifdef PIC24_ICSP_NOPPAD_EN
    assign shifting = (state_q == S_SHIFT) || ((state_q == S_NOP) && nop_run_q);
`else
    assign shifting = (state_q == S_SHIFT);
`endif

    pic24_icsp_bitclk #(.CLKDIV(CLKDIV)) u_bitclk (
        .clk        (clk),
        .rstn       (rstn),
        .en_i       (shifting),
        .tick_o     (tick),
        .phase_hi_o (phase_hi)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        ce_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pgc_d   = pgc_q;
        pgd_d   = pgd_q;
        oe_d    = oe_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        advance = 1'b0;
`ifdef PIC24_ICSP_NOPPAD_EN
        nop_run_d = nop_run_q;
        gap_d     = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        rem_d   = count - 1'b1;
                        addr_d  = '0;
                        ce_d    = 1'b1;
                        busy_d  = 1'b1;
                        oe_d    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                shift_d = {mem_dout[OPERAND_BITS-1:0], SIX_CMD};
                bit_d   = '0;
                pgc_d   = 1'b1;
                pgd_d   = SIX_CMD[0];
                state_d = S_SHIFT;
            end
            S_SHIFT: ;
`ifdef PIC24_ICSP_NOPPAD_EN
            // First two NOP cycles reproduce the FETCH/WAIT gap without touching memory.
            S_NOP: begin
                if (!nop_run_q) begin
                    if (gap_q) begin
                        shift_d   = {NOP_OPERAND, SIX_CMD};
                        bit_d     = '0;
                        pgc_d     = 1'b1;
                        pgd_d     = SIX_CMD[0];
                        nop_run_d = 1'b1;
                    end else begin
                        gap_d = 1'b1;
                    end
                end
            end
`endif
            // Entered with done_q set from the shift path; the count=0 path pulses one cycle later.
            S_DONE: begin
                if (done_q) begin
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    pgd_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (shifting && tick) begin
            if (phase_hi) begin
                pgc_d = 1'b0;
            end else if (bit_q == LAST_BIT) begin
`ifdef PIC24_ICSP_NOPPAD_EN
                if (state_q == S_SHIFT) begin
                    state_d   = S_NOP;
                    gap_d     = 1'b0;
                    nop_run_d = 1'b0;
                end else begin
                    advance = 1'b1;
                end
`else
                advance = 1'b1;
`endif
            end else begin
                bit_d   = bit_q + 5'd1;
                shift_d = shift_q >> 1;
                pgc_d   = 1'b1;
                pgd_d   = shift_q[1];
            end
        end

        if (advance) begin
            if (rem_q != '0) begin
                rem_d   = rem_q - 1'b1;
                addr_d  = addr_q + 1'b1;
                ce_d    = 1'b1;
                state_d = S_FETCH;
            end else begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pgc_q   <= 1'b0;
            pgd_q   <= 1'b0;
            oe_q    <= 1'b0;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pgc_q   <= pgc_d;
            pgd_q   <= pgd_d;
            oe_q    <= oe_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
        end
    end

`ifdef PIC24_ICSP_NOPPAD_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nop_run_q <= 1'b0;
            gap_q     <= 1'b0;
        end else begin
            nop_run_q <= nop_run_d;
            gap_q     <= gap_d;
        end
    end
`endif

    generate
        if (DATAWIDTH > OPERAND_BITS) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^mem_dout[DATAWIDTH-1:OPERAND_BITS];
        end
    endgenerate

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_addr = addr_q;
    assign mem_ce   = ce_q;
    assign mem_we   = 1'b0;
    assign pgc      = pgc_q;
    assign pgd      = pgd_q;
    assign pgd_oe   = oe_q;

endmodule

// File: tb/tb_pic24_icsp_six_sender.sv
// Directed bench for pic24_icsp_six_sender with a registered memory model and a PGC-falling-edge receiver.
module tb_pic24_icsp_six_sender;

    localparam int CLKDIV = 2;
    localparam int AW     = 7;
    localparam int DW     = 32;
`ifdef PIC24_ICSP_NOPPAD_EN
    localparam int PPW = 2;
`else
    localparam int PPW = 1;
`endif
    localparam int LAT_W = PPW * (2 + 56 * CLKDIV);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   count = '0;
    logic          busy, done, mem_ce, mem_we, pgc, pgd, pgd_oe;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc, done_cyc;
    int ce_cnt, done_cnt, gap_cnt, bad_run, low_run, rx_n;
    int first_addr, last_addr;
    bit busy_seen, pgc_seen, seen_hi, we_seen;
    logic [27:0] rx_sr;
    logic [27:0] rx_q [$];
    logic [23:0] exp_q [$];

    pic24_icsp_six_sender #(.DATAWIDTH(DW), .MEMSIZElog2(AW), .CLKDIV(CLKDIV)) dut (
        .clk(clk), .rstn(rstn), .start(start), .count(count), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we), .mem_dout(mem_dout),
        .pgc(pgc), .pgd(pgd), .pgd_oe(pgd_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_ce) mem_dout <= mem[mem_addr];
    end

    always @(negedge pgc) begin
        if (rstn) begin
            rx_sr = {pgd, rx_sr[27:1]};
            rx_n++;
            if (rx_n == 28) begin
                rx_q.push_back(rx_sr);
                rx_n = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_ce) begin
            if (ce_cnt == 0) first_addr = int'(mem_addr);
            last_addr = int'(mem_addr);
            ce_cnt++;
        end
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
        if (busy) busy_seen = 1'b1;
        if (mem_we) we_seen = 1'b1;
        if (pgc) begin
            pgc_seen = 1'b1;
            if (seen_hi && low_run > 0) begin
                if (low_run == CLKDIV + 2) gap_cnt++;
                else if (low_run != CLKDIV) bad_run++;
            end
            seen_hi = 1'b1;
            low_run = 0;
        end else if (seen_hi) begin
            low_run++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        ce_cnt = 0; done_cnt = 0; gap_cnt = 0; bad_run = 0; low_run = 0; rx_n = 0;
        first_addr = -1; last_addr = -1; done_cyc = 0;
        busy_seen = 1'b0; pgc_seen = 1'b0; seen_hi = 1'b0;
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic launch(input int c);
        @(negedge clk);
        count = c[AW:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
    endtask

    task automatic chk_pkts(input string tag);
        int bad;
        int j;
        logic [27:0] e;
        bad = 0;
        chk({tag, "_npkt"}, rx_q.size(), exp_q.size() * PPW);
        for (int i = 0; i < exp_q.size(); i++) begin
            for (int p = 0; p < PPW; p++) begin
                j = i * PPW + p;
                e = (p == 0) ? {exp_q[i], 4'h0} : 28'h0;
                if (j >= rx_q.size()) bad++;
                else if (rx_q[j] !== e) bad++;
            end
        end
        chk({tag, "_data"}, bad, 0);
    endtask

    initial begin
        int n;
        we_seen = 1'b0;
        clr();
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ce", mem_ce, 0);
        chk("rst_pgc_pgd_oe", {pgc, pgd, pgd_oe}, 3'b000);
        chk("rst_addr", mem_addr, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // single word, cmd nibble then operand 0x040200
        clr();
        mem[0] = 32'h0004_0200;
        exp_q.push_back(24'h040200);
        launch(1);
        chk("a_busy", busy, 1);
        chk("a_ce_addr", {mem_ce, pgd_oe, 1'b0, mem_addr}, {1'b1, 1'b1, 1'b0, 7'd0});
        wait_done(LAT_W + 50);
        chk("a_latency", done_cyc - start_cyc, LAT_W);
        chk("a_ce_cnt", ce_cnt, 1);
        chk("a_addr", first_addr, 0);
        chk_pkts("a");
        chk("a_idle_out", {busy, pgd_oe, pgd, pgc}, 4'b0000);

        // upper data byte must not appear on the wire
        clr();
        mem[0] = 32'hFF12_3456;
        exp_q.push_back(24'h123456);
        launch(1);
        wait_done(LAT_W + 50);
        chk_pkts("b");

        // count = 0
        clr();
        launch(0);
        wait_done(20);
        chk("c_latency", done_cyc - start_cyc, 1);
        chk("c_quiet", {busy_seen, pgc_seen}, 2'b00);
        chk("c_ce_cnt", ce_cnt, 0);

        // full memory, count = 2^AW
        clr();
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = i;
            exp_q.push_back(i[23:0]);
        end
        launch(1 << AW);
        wait_done((1 << AW) * LAT_W + 100);
        chk("d_latency", done_cyc - start_cyc, (1 << AW) * LAT_W);
        chk("d_ce_cnt", ce_cnt, 1 << AW);
        chk("d_last_addr", last_addr, (1 << AW) - 1);
        chk("d_addr_hold", mem_addr, (1 << AW) - 1);
        chk("d_gaps", gap_cnt, (1 << AW) * PPW - 1);
        chk("d_bad_low_run", bad_run, 0);
        chk_pkts("d");

        // start re-pulsed while busy
        clr();
        for (int i = 0; i < 3; i++) exp_q.push_back(i[23:0]);
        launch(3);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3 * LAT_W + 50);
        chk("e_latency", done_cyc - start_cyc, 3 * LAT_W);
        chk("e_ce_cnt", ce_cnt, 3);
        chk_pkts("e");
        repeat (20) @(negedge clk);
        chk("e_no_second", {28'd0, done_cnt, busy}, {28'd0, 32'd1, 1'b0});

        // reset in the middle of bit 10 of the second word
        clr();
        launch(3);
        n = 0;
        while (!(rx_q.size() == PPW && rx_n == 10) && n < 3 * LAT_W) begin
            @(negedge clk);
            n++;
        end
        chk("f_reached_bit10", rx_n, 10);
        #1 rstn = 1'b0;
        #1;
        chk("f_rst_outs", {busy, done, mem_ce, mem_we, pgc, pgd, pgd_oe}, 7'd0);
        chk("f_rst_addr", mem_addr, 0);
        repeat (5) @(negedge clk);
        chk("f_no_done", done_cnt, 0);
        rstn = 1'b1;
        @(negedge clk);
        clr();
        mem[0] = 32'h00AB_CDEF;
        exp_q.push_back(24'hABCDEF);
        launch(1);
        wait_done(LAT_W + 50);
        chk("f_first_addr", first_addr, 0);
        chk("f_ce_cnt", ce_cnt, 1);
        chk_pkts("f");

        chk("we_never", we_seen, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
